// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column-multiplexed scan, sweep-level debounce,
// and a 32-bit shift register of accepted hex digits (newest in [3:0]).
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_enable,
  input  logic        clear_data,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [31:0] entered_data,
  output logic [3:0]  digit_count
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  logic [3:0]    row_meta, row_sync;
  logic          active;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [11:0]   sweep_img;
  logic          dwell_last, sweep_done;
  logic [15:0]   image;
  logic [4:0]    hits;
  logic [3:0]    hit_idx;
  logic          is_none, is_single;
  logic [3:0]    single_key;

  state_t        state, state_nxt;
  logic [3:0]    cand, cand_nxt;
  logic [CW-1:0] stable_cnt, stable_nxt;
  logic [CW-1:0] rel_cnt, rel_nxt;
  logic          accept;

  // Image bit index is col*4 + row.
  function automatic logic [3:0] key_of(input logic [3:0] idx);
    logic [3:0] k;
    case (idx)
      4'd0:    k = 4'h1;
      4'd1:    k = 4'h4;
      4'd2:    k = 4'h7;
      4'd3:    k = 4'h0;
      4'd4:    k = 4'h2;
      4'd5:    k = 4'h5;
      4'd6:    k = 4'h8;
      4'd7:    k = 4'hF;
      4'd8:    k = 4'h3;
      4'd9:    k = 4'h6;
      4'd10:   k = 4'h9;
      4'd11:   k = 4'hE;
      4'd12:   k = 4'hA;
      4'd13:   k = 4'hB;
      4'd14:   k = 4'hC;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  assign dwell_last = active && (dwell == DWELL_LAST);
  assign sweep_done = scan_enable && dwell_last && (col_idx == 2'd3);
  assign col_n      = active ? ~(4'b0001 << col_idx) : 4'b1111;

  // One idle cycle after enable arms the scan so column 0 gets a full dwell.
  always_ff @(posedge clk) begin
    if (reset || !scan_enable) begin
      active    <= 1'b0;
      dwell     <= '0;
      col_idx   <= '0;
      sweep_img <= '0;
    end else if (!active) begin
      active <= 1'b1;
    end else if (dwell_last) begin
      dwell   <= '0;
      col_idx <= col_idx + 2'd1;
      case (col_idx)
        2'd0:    sweep_img[3:0]  <= ~row_sync;
        2'd1:    sweep_img[7:4]  <= ~row_sync;
        2'd2:    sweep_img[11:8] <= ~row_sync;
        default: ;
      endcase
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Column 3 is classified straight from the synchroniser on its last dwell cycle.
  assign image = {~row_sync, sweep_img};

  always_comb begin
    hits    = '0;
    hit_idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (image[i]) begin
        hits    = hits + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign is_none    = (hits == 5'd0);
  assign is_single  = (hits == 5'd1);
  assign single_key = key_of(hit_idx);

  always_ff @(posedge clk) begin
    if (reset || !scan_enable) begin
      state      <= IDLE;
      cand       <= '0;
      stable_cnt <= '0;
      rel_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      cand       <= cand_nxt;
      stable_cnt <= stable_nxt;
      rel_cnt    <= rel_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    stable_nxt = stable_cnt;
    rel_nxt    = rel_cnt;
    accept     = 1'b0;
    if (sweep_done) begin
      case (state)
        IDLE: begin
          if (is_single) begin
            cand_nxt   = single_key;
            stable_nxt = CW'(1);
            if (DEBOUNCE_CNT <= 1) begin
              accept    = 1'b1;
              state_nxt = HELD;
            end else begin
              state_nxt = PRESS_WAIT;
            end
          end
        end
        PRESS_WAIT: begin
          if (is_single && (single_key == cand)) begin
            stable_nxt = stable_cnt + CW'(1);
            if ((stable_cnt + CW'(1)) >= DEB_MAX) begin
              accept    = 1'b1;
              state_nxt = HELD;
            end
          end else if (is_single) begin
            cand_nxt   = single_key;
            stable_nxt = CW'(1);
          end else begin
            stable_nxt = '0;
            state_nxt  = IDLE;
          end
        end
        HELD: begin
          if (is_none) begin
            rel_nxt   = CW'(1);
            state_nxt = (DEBOUNCE_CNT <= 1) ? IDLE : RELEASE_WAIT;
          end
        end
        default: begin
          if (is_none) begin
            rel_nxt = rel_cnt + CW'(1);
            if ((rel_cnt + CW'(1)) >= DEB_MAX) begin
              rel_nxt   = '0;
              state_nxt = IDLE;
            end
          end else begin
            rel_nxt   = '0;
            state_nxt = HELD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_code     <= '0;
      key_valid    <= 1'b0;
      entered_data <= '0;
      digit_count  <= '0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= cand_nxt;
      if (clear_data) begin
        entered_data <= '0;
        digit_count  <= '0;
      end else if (accept) begin
        entered_data <= {entered_data[27:0], cand_nxt};
        if (digit_count != 4'd8) digit_count <= digit_count + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed plan then random key
// sessions, checked against a sweep-level keypad/debounce model.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int SWEEP    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset, scan_enable, clear_data;
  logic [3:0]  row_n, col_n, key_code, digit_count;
  logic        key_valid;
  logic [31:0] entered_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] pressed;
  logic [3:0]  kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                             4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC,
                             4'h0, 4'hF, 4'hE, 4'hD};

  logic [3:0]  exp_code;
  logic [31:0] exp_data;
  int          exp_count;
  bit          exp_pulse;
  bit          locked;
  int          run_len, none_run;
  logic [3:0]  run_key;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
    .clk(clk), .reset(reset), .scan_enable(scan_enable), .clear_data(clear_data),
    .row_n(row_n), .col_n(col_n), .key_code(key_code), .key_valid(key_valid),
    .entered_data(entered_data), .digit_count(digit_count)
  );

  // Keypad matrix: pressed bit r*4+c shorts row r to column c.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] key_bit(input logic [3:0] d);
    logic [15:0] b = '0;
    for (int i = 0; i < 16; i++) if (kmap[i] == d) b = 16'h1 << i;
    return b;
  endfunction

  // A press is accepted after DEB identical single-key sweeps; the keypad
  // re-arms only after DEB consecutive empty sweeps.
  task automatic model_sweep(input logic [15:0] k, input bit clr);
    int n = $countones(k);
    int idx = 0;
    for (int i = 0; i < 16; i++) if (k[i]) idx = i;
    exp_pulse = 0;
    if (locked) begin
      if (n == 0) begin
        none_run++;
        if (none_run >= DEB) begin locked = 0; run_len = 0; end
      end else none_run = 0;
    end else if (n == 1) begin
      if (run_len > 0 && kmap[idx] == run_key) run_len++;
      else begin run_key = kmap[idx]; run_len = 1; end
      if (run_len >= DEB) begin
        exp_pulse = 1;
        exp_code  = run_key;
        exp_data  = {exp_data[27:0], run_key};
        if (exp_count < 8) exp_count++;
        locked   = 1;
        none_run = 0;
      end
    end else run_len = 0;
    if (clr) begin exp_data = '0; exp_count = 0; end
  endtask

  task automatic sweep(input logic [15:0] k, input bit clr);
    logic [3:0] ec;
    pressed = k;
    for (int i = 0; i < SWEEP; i++) begin
      @(posedge clk); @(negedge clk);
      ec = ~(4'b0001 << (i / SCAN_DIV));
      check("col_n", col_n, ec);
      if (i == 0) begin
        clear_data = 1'b0;
        check("key_valid", key_valid, exp_pulse);
        check("key_code", key_code, exp_code);
        check("entered_data", entered_data, exp_data);
        check("digit_count", digit_count, exp_count);
      end else begin
        check("key_valid_quiet", key_valid, 0);
      end
      if (i == SWEEP - 1) clear_data = clr;
    end
    model_sweep(k, clr);
  endtask

  task automatic press(input logic [3:0] d);
    repeat (DEB) sweep(key_bit(d), 1'b0);
    repeat (DEB) sweep('0, 1'b0);
  endtask

  initial begin
    logic [15:0] kb;
    logic [3:0]  digits [10];
    int          b1, b2, len, sel;
    bit          clr;

    reset = 1'b1; scan_enable = 1'b0; clear_data = 1'b0; pressed = '0;
    exp_code = '0; exp_data = '0; exp_count = 0; exp_pulse = 0;
    locked = 0; run_len = 0; none_run = 0; run_key = '0;
    repeat (3) @(negedge clk);
    check("rst_col_n", col_n, 4'b1111);
    check("rst_key_code", key_code, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_entered_data", entered_data, 0);
    check("rst_digit_count", digit_count, 0);

    reset = 1'b0; scan_enable = 1'b1;
    repeat (2) sweep('0, 1'b0);

    repeat (5) sweep(key_bit(4'h6), 1'b0);
    repeat (2) sweep('0, 1'b0);
    check("after_6_data", entered_data, 32'h00000006);
    check("after_6_count", digit_count, 4'd1);

    press(4'h1);
    sweep(key_bit(4'h9), 1'b0);
    sweep('0, 1'b0);
    press(4'hA);
    press(4'h0);
    check("seq_data", entered_data, 32'h000061A0);
    check("seq_count", digit_count, 4'd4);

    digits = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'h0};
    foreach (digits[i]) press(digits[i]);
    check("wrap_data", entered_data, 32'h34567890);
    check("wrap_count", digit_count, 4'd8);

    repeat (4) sweep(16'h0001 | 16'h0200, 1'b0);
    repeat (2) sweep('0, 1'b0);
    check("multi_count", digit_count, 4'd8);

    sweep(key_bit(4'hC), 1'b0);
    sweep(key_bit(4'hC), 1'b1);
    sweep('0, 1'b0);
    check("clr_key_code", key_code, 4'hC);
    check("clr_data", entered_data, 0);
    check("clr_count", digit_count, 0);
    sweep('0, 1'b0);

    // Disable partway through a debounce with the key still held.
    sweep(key_bit(4'h5), 1'b0);
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); @(negedge clk);
      check("part_key_valid", key_valid, (j == 0) ? 32'(exp_pulse) : 32'd0);
    end
    scan_enable = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); @(negedge clk);
      check("dis_col_n", col_n, 4'b1111);
      check("dis_key_valid", key_valid, 0);
    end
    locked = 0; run_len = 0; none_run = 0; exp_pulse = 0;
    scan_enable = 1'b1;
    sweep(key_bit(4'h5), 1'b0);
    sweep(key_bit(4'h5), 1'b0);
    sweep('0, 1'b0);
    check("reen_key_code", key_code, 4'h5);
    check("reen_count", digit_count, 4'd1);
    sweep('0, 1'b0);

    for (int s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 4);
      if (sel < 4) kb = '0;
      else if (sel < 8) kb = 16'h1 << $urandom_range(0, 15);
      else begin
        b1 = $urandom_range(0, 15);
        b2 = (b1 + $urandom_range(1, 15)) % 16;
        kb = (16'h1 << b1) | (16'h1 << b2);
      end
      for (int r = 0; r < len; r++) begin
        clr = ($urandom_range(0, 15) == 0);
        sweep(kb, clr);
      end
    end
    repeat (2) sweep('0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display path: time-multiplexes a 4x4 hex keypad, debounces presses, and assembles entered hex digits into a 32-bit word.
- The assembled word feeds the CPU memory-mapped input and the display path.
- Scans one column at a time with active-low drive and reads the active-low rows.

Parameters:
- SCAN_DIV, 50000: clock cycles each column is driven; the dwell period.
- DEBOUNCE_CNT, 4: consecutive identical full sweeps required to accept a press or a release.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- scan_enable  input  1  scanning runs when high
- clear_data  input  1  synchronous clear of entered_data and digit_count
- row_n  input  4  keypad rows, active-low, asynchronous to clk
- col_n  output  4  keypad column drive, active-low, one-hot-low
- key_code  output  4  last accepted key value
- key_valid  output  1  one-cycle pulse on each accepted press
- entered_data  output  32  shift register of accepted digits, newest digit in [3:0]
- digit_count  output  4  number of digits entered, saturates at 8

Behaviour:
- Clock and reset: single clock domain. reset is synchronous and active-high.
- Reset values:
  - col_n = 4'b1111
  - key_code = 0
  - key_valid = 0
  - entered_data = 0
  - digit_count = 0
  - FSM = IDLE, all counters = 0
- Input synchronisation: row_n passes through a 2-flop synchroniser before any use.
- Scan:
  - Dwell counter counts 0..SCAN_DIV-1. Column index col_idx (2 bits) increments on wrap, 3 -> 0.
  - col_n = ~(4'b0001 << col_idx).
  - Synchronised rows are sampled on the last dwell cycle of each column into a 16-bit sweep image.
  - The sweep completes on the last dwell cycle of col_idx = 3 (one sweep = 4*SCAN_DIV cycles), producing a one-cycle sweep_done.
- Sweep classification:
  - NONE: zero keys asserted.
  - SINGLE(k): exactly one key asserted.
  - MULTI: two or more keys asserted. MULTI is treated as NONE for press acceptance and does not count toward release.
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM, evaluated only on sweep_done:
  - IDLE: on SINGLE(k), latch cand = k, stable_cnt = 1, go to PRESS_WAIT.
  - PRESS_WAIT:
    - SINGLE(cand): stable_cnt++.
    - When stable_cnt reaches DEBOUNCE_CNT: go to HELD and perform acceptance on that same cycle.
    - SINGLE(other key): restart with cand = new key, stable_cnt = 1.
    - NONE or MULTI: return to IDLE.
  - Acceptance:
    - key_code <= cand, key_valid = 1 for exactly one clk.
    - entered_data <= {entered_data[27:0], cand}.
    - digit_count <= min(digit_count + 1, 8).
  - HELD: on NONE, rel_cnt = 1, go to RELEASE_WAIT. Any other result stays in HELD. Holding a key never auto-repeats.
  - RELEASE_WAIT:
    - NONE: rel_cnt++. When rel_cnt reaches DEBOUNCE_CNT, go to IDLE.
    - Any key: return to HELD.
- DEBOUNCE_CNT = 1 accepts on the first SINGLE sweep.
- Press latency: key_valid pulses on the sweep_done of the DEBOUNCE_CNT-th consecutive SINGLE sweep.
- Wrap-around: after 8 digits, further digits continue to shift; the oldest nibble is discarded and digit_count stays 8.
- clear_data:
  - Sets entered_data = 0 and digit_count = 0 on the next edge. FSM and scan are unaffected.
  - If coincident with acceptance, clear wins: data = 0 and count = 0. key_valid still pulses and key_code still updates.
- scan_enable low:
  - Dwell counter, col_idx, stable_cnt and rel_cnt are forced to 0.
  - col_n = 4'b1111, FSM = IDLE.
  - key_code, entered_data and digit_count are retained.
  - Re-enable starts a fresh sweep at column 0.
- reset mid-press: reset forces all reset values; a key still held afterwards is re-debounced from IDLE.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=2, sweep = 16 cycles):
- Reset, enable, no keys -> col_n cycles 1110, 1101, 1011, 0111, 4 cycles each; key_valid never asserts; entered_data = 0.
- Hold key r1c2 ('6') for 5 sweeps -> exactly one key_valid pulse at the end of sweep 2; key_code = 6; entered_data = 0x00000006; digit_count = 1.
- Release 2 sweeps, then press '1', 'A', '0' each with full debounce and release -> entered_data = 0x000061A0, digit_count = 4. A 1-sweep glitch of '9' between presses -> no pulse.
- Press 10 keys 1..9, then 0 -> entered_data = 0x34567890, digit_count = 8.
- Two keys held simultaneously (r0c0 + r2c1) for 4 sweeps -> no key_valid. Assert clear_data on the same cycle as an accepted 'C' -> key_code = C, entered_data = 0, digit_count = 0.
- Drop scan_enable mid-PRESS_WAIT, re-enable with key held -> col_n = 1111 while disabled; the full 2-sweep debounce restarts from column 0 before key_valid.
